// File: rtl/log2_pipe.sv
// log2_pipe: three-stage pipelined binary-logarithm converter using the
// Mitchell approximation. The result is the leading-one position (integer
// part of log2) plus the bits below it, MSB-aligned, as the fraction.
//
// Stage 1 registers the operand magnitude and sign.
// Stage 2 finds the leading one with a tree of 4-bit detectors.
// Stage 3 normalises the mantissa and optionally applies a two-region
//   error correction, then drives the registered outputs.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand valid
//   in_ready   block accepts an operand this cycle
//   in_data    operand, DATA_W bits (two's complement when SIGNED_IN=1)
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_pos    leading-one index, POS_W bits
//   out_frac   fraction, FRAC_W bits
//   out_zero   operand magnitude was zero
//   out_sign   operand sign (always 0 when SIGNED_IN=0)
//
// The whole pipeline advances together: when the output holds a result
// that is not taken, every stage freezes. Bubbles are carried, not squeezed.

module log2_pipe #(
  parameter int DATA_W    = 16,
  parameter int FRAC_W    = 12,
  parameter int SIGNED_IN = 0,
  parameter int CORR_EN   = 0,
  parameter int POS_W     = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [POS_W-1:0]  out_pos,
  output logic [FRAC_W-1:0] out_frac,
  output logic              out_zero,
  output logic              out_sign
);

  localparam int NG = DATA_W / 4;      // number of 4-bit groups
  localparam int LG = $clog2(NG);      // merge levels in the detector tree

  // Leading-one detect: each nibble yields (any, absolute index), then
  // pairs are merged level by level, preferring the upper half. The merge
  // is done in place; node i at one level only reads nodes 2i and 2i+1,
  // which are never overwritten before being read.
  function automatic logic [POS_W:0] lod_tree(input logic [DATA_W-1:0] m);
    logic             node_v [NG];
    logic [POS_W-1:0] node_p [NG];
    logic [3:0]       nib;
    logic [1:0]       loc;
    for (int g = 0; g < NG; g++) begin
      nib = m[4*g +: 4];
      casez (nib)
        4'b1???: loc = 2'd3;
        4'b01??: loc = 2'd2;
        4'b001?: loc = 2'd1;
        default: loc = 2'd0;
      endcase
      node_v[g] = |nib;
      node_p[g] = POS_W'(4 * g) + {{(POS_W-2){1'b0}}, loc};
    end
    for (int l = 0; l < LG; l++) begin
      for (int i = 0; i < (NG >> (l + 1)); i++) begin
        node_p[i] = node_v[2*i+1] ? node_p[2*i+1] : node_p[2*i];
        node_v[i] = node_v[2*i+1] | node_v[2*i];
      end
    end
    return {node_v[0], node_p[0]};
  endfunction

  // Two-region Mitchell correction. Below one half the error grows with f,
  // above one half it shrinks with (1 - f); a quarter of either is added.
  // The sum cannot really exceed all-ones, but it is clamped so the fraction
  // can never wrap or spill into the integer part.
  function automatic logic [FRAC_W-1:0] mitchell_corr(input logic [FRAC_W-1:0] f);
    logic [FRAC_W-1:0] addend;
    logic [FRAC_W:0]   sum;
    addend = f[FRAC_W-1] ? ((~f) >> 2'd2) : (f >> 2'd2);
    sum    = {1'b0, f} + {1'b0, addend};
    return sum[FRAC_W] ? {FRAC_W{1'b1}} : sum[FRAC_W-1:0];
  endfunction

  logic              adv;
  logic              sign_in;
  logic [DATA_W-1:0] mag_in;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_mag;
  logic              s1_sign;

  logic [POS_W:0]    lod_res;

  logic              s2_valid;
  logic [DATA_W-1:0] s2_mag;
  logic [POS_W-1:0]  s2_pos;
  logic              s2_zero;
  logic              s2_sign;

  logic [POS_W:0]    shamt;
  logic [FRAC_W-1:0] frac_raw;
  logic [FRAC_W-1:0] frac_fin;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;
  assign lod_res  = lod_tree(s1_mag);

  // Operand magnitude and sign. The negation is done one bit wider so the
  // most negative operand yields its true magnitude 2^(DATA_W-1).
  always_comb begin
    sign_in = 1'b0;
    mag_in  = in_data;
    if (SIGNED_IN != 0) begin
      sign_in = in_data[DATA_W-1];
      if (in_data[DATA_W-1]) begin
        mag_in = DATA_W'({(DATA_W+1){1'b0}} - {in_data[DATA_W-1], in_data});
      end else begin
        mag_in = in_data;
      end
    end else begin
      sign_in = 1'b0;
      mag_in  = in_data;
    end
  end

  // Stage 1 register: magnitude and sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mag   <= '0;
      s1_sign  <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_mag   <= mag_in;
      s1_sign  <= sign_in;
    end
  end

  // Stage 2 register: magnitude, leading-one position, zero flag, sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_mag   <= '0;
      s2_pos   <= '0;
      s2_zero  <= 1'b0;
      s2_sign  <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_mag   <= s1_mag;
      s2_pos   <= lod_res[POS_W] ? lod_res[POS_W-1:0] : {POS_W{1'b0}};
      s2_zero  <= !lod_res[POS_W];
      s2_sign  <= s1_sign;
    end
  end

  // Mantissa normalisation. Shifting left by (DATA_W - pos) pushes the
  // leading one out of the top of the magnitude field, leaving the bits
  // below it at the top; the FRAC_W zeros appended below supply zero-fill
  // when pos < FRAC_W, and the low bits are simply dropped when pos > FRAC_W.
  // pos = 0 shifts by DATA_W and gives an all-zero fraction.
  always_comb begin
    shamt    = (POS_W+1)'(DATA_W) - {1'b0, s2_pos};
    frac_raw = FRAC_W'(({s2_mag, {FRAC_W{1'b0}}} << shamt) >> DATA_W);
    if (s2_zero) begin
      frac_fin = {FRAC_W{1'b0}};
    end else if (CORR_EN != 0) begin
      frac_fin = mitchell_corr(frac_raw);
    end else begin
      frac_fin = frac_raw;
    end
  end

  // Stage 3 register: the block outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pos   <= '0;
      out_frac  <= '0;
      out_zero  <= 1'b0;
      out_sign  <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_valid;
      out_pos   <= s2_zero ? {POS_W{1'b0}} : s2_pos;
      out_frac  <= frac_fin;
      out_zero  <= s2_zero;
      out_sign  <= s2_sign;
    end
  end

endmodule
